uart_tx_scheduler: RTL and testbench

- Round-robin, packet-locked scheduler that shares one UART transmitter between NUM_REQ byte-stream requesters.
- Sits between the requesters and the UART core's host write port (CSN/WEN/DATA_IN), and paces writes with the core's TXRDY.
- A requester holds the transmitter from grant until it delivers a byte flagged LAST, so packets never interleave on the serial line.

---
 rtl/uart_sched_pkg.sv | 25 ++
 rtl/uart_tx_scheduler_arb.sv | 31 +++
 rtl/uart_tx_scheduler.sv | 175 +++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_sched_pkg.sv
// Shared types and limits for the UART transmit scheduler.
// State encoding, counter widths and parameter ranges.
package uart_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_GUARD,
    ST_WAIT,
    ST_RELEASE
  } state_e;

  localparam int GCNT_W    = 3;
  localparam int STALL_W   = 16;
  localparam int REQ_MIN   = 2;
  localparam int REQ_MAX   = 8;
  localparam int GUARD_MIN = 1;
  localparam int GUARD_MAX = 7;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_scheduler_arb.sv
// Round-robin pick: first request at or above ptr, with wrap.
// Returns both a one-hot grant and its index.
module uart_rr_arbiter #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  logic          hit;
  logic [PW-1:0] k;

  always_comb begin
    gnt = '0;
    idx = '0;
    hit = 1'b0;
    k   = '0;
    for (int i = 0; i < N; i++) begin
      k = PW'((int'(ptr) + i) % N);
      if (!hit && req[k]) begin
        hit    = 1'b1;
        gnt[k] = 1'b1;
        idx    = k;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Packet-locked round-robin scheduler sharing one UART
// transmitter between NUM_REQ byte-stream requesters.
module uart_tx_scheduler
  import uart_sched_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int GUARD_CYCLES  = 2,
  parameter int STALL_TIMEOUT = 0
) (
  input  logic                 CLK,
  input  logic                 RESET_N,
  input  logic [NUM_REQ-1:0]   REQ_VALID,
  input  logic [8*NUM_REQ-1:0] REQ_DATA,
  input  logic [NUM_REQ-1:0]   REQ_LAST,
  output logic [NUM_REQ-1:0]   REQ_READY,
  input  logic                 TXRDY,
  output logic                 CSN,
  output logic                 WEN,
  output logic [7:0]           DATA_IN,
  output logic [NUM_REQ-1:0]   GRANT,
  output logic                 BUSY,
  output logic                 PKT_DONE,
  output logic                 ABORT
);

  localparam int PW = idx_w(NUM_REQ);
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);
  localparam logic [GCNT_W-1:0] G_END = GCNT_W'(GUARD_CYCLES - 1);
  localparam logic [STALL_W-1:0] TMO = STALL_W'(STALL_TIMEOUT);

  state_e               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [PW-1:0]        own_q, own_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic                 busy_q, busy_d;
  logic [7:0]           data_q, data_d;
  logic                 last_q, last_d;
  logic                 wr_n_q, wr_n_d;
  logic                 done_q, done_d;
  logic                 abort_q, abort_d;
  logic [GCNT_W-1:0]    gcnt_q, gcnt_d;
  logic [STALL_W-1:0]   stall_q, stall_d;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [PW-1:0]        arb_idx;
  logic [PW-1:0]        nxt_ptr;
  logic [STALL_W-1:0]   stall_inc;
  logic                 own_valid;
  logic                 accept;
  logic                 stall_hit;

  uart_rr_arbiter #(
    .N  (NUM_REQ),
    .PW (PW)
  ) u_arb (
    .req (REQ_VALID),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  assign own_valid = REQ_VALID[own_q];
  assign accept    = (state_q == ST_LOAD) && own_valid && TXRDY;
  assign stall_inc = stall_q + 1'b1;
  assign stall_hit = (TMO != '0) && (stall_inc == TMO);
  assign nxt_ptr   = (own_q == LAST_IDX) ? '0 : own_q + 1'b1;
  assign REQ_READY = accept ? grant_q : '0;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      wr_n_q  <= 1'b1;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      gcnt_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
      last_q  <= last_d;
      wr_n_q  <= wr_n_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      gcnt_q  <= gcnt_d;
      stall_q <= stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (|REQ_VALID) state_d = ST_LOAD;
      ST_LOAD: begin
        if (accept) state_d = ST_WRITE;
        else if (!own_valid && stall_hit) state_d = ST_IDLE;
      end
      ST_WRITE:   state_d = ST_GUARD;
      ST_GUARD:   if (gcnt_q == G_END) state_d = ST_WAIT;
      ST_WAIT:    if (TXRDY) state_d = last_q ? ST_RELEASE : ST_LOAD;
      ST_RELEASE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Registered outputs are set on entry so they line up with the state.
  always_comb begin
    ptr_d   = ptr_q;
    own_d   = own_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    data_d  = data_q;
    last_d  = last_q;
    wr_n_d  = 1'b1;
    done_d  = 1'b0;
    abort_d = 1'b0;
    gcnt_d  = gcnt_q;
    stall_d = stall_q;
    unique case (state_q)
      ST_IDLE: begin
        stall_d = '0;
        if (|REQ_VALID) begin
          grant_d = arb_gnt;
          own_d   = arb_idx;
          busy_d  = 1'b1;
        end
      end
      ST_LOAD: begin
        if (accept) begin
          data_d  = REQ_DATA[{own_q, 3'b000} +: 8];
          last_d  = REQ_LAST[own_q];
          wr_n_d  = 1'b0;
          stall_d = '0;
        end else if (!own_valid) begin
          stall_d = stall_inc;
          if (stall_hit) begin
            abort_d = 1'b1;
            grant_d = '0;
            busy_d  = 1'b0;
            ptr_d   = nxt_ptr;
          end
        end
      end
      ST_WRITE: gcnt_d = '0;
      ST_GUARD: gcnt_d = gcnt_q + 1'b1;
      ST_WAIT: begin
        if (TXRDY && last_q) begin
          done_d  = 1'b1;
          grant_d = '0;
          busy_d  = 1'b0;
        end
      end
      ST_RELEASE: ptr_d = nxt_ptr;
      default: ;
    endcase
  end

  assign CSN      = wr_n_q;
  assign WEN      = wr_n_q;
  assign DATA_IN  = data_q;
  assign GRANT    = grant_q;
  assign BUSY     = busy_q;
  assign PKT_DONE = done_q;
  assign ABORT    = abort_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler (4 requesters,
// guard 2, stall timeout 10).
module tb_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_last = '0;
  logic [3:0]  req_ready;
  logic        txrdy = 1'b1;
  logic        csn, wen;
  logic [7:0]  data_in;
  logic [3:0]  grant;
  logic        busy, pkt_done, abort;

  always #5 clk = ~clk;

  uart_tx_scheduler #(
    .NUM_REQ       (4),
    .GUARD_CYCLES  (2),
    .STALL_TIMEOUT (10)
  ) dut (
    .CLK       (clk),
    .RESET_N   (rst_n),
    .REQ_VALID (req_valid),
    .REQ_DATA  (req_data),
    .REQ_LAST  (req_last),
    .REQ_READY (req_ready),
    .TXRDY     (txrdy),
    .CSN       (csn),
    .WEN       (wen),
    .DATA_IN   (data_in),
    .GRANT     (grant),
    .BUSY      (busy),
    .PKT_DONE  (pkt_done),
    .ABORT     (abort)
  );

  typedef struct {
    int         own;
    logic [7:0] d;
  } exp_t;

  logic [8:0] rq [4][$];
  exp_t       sb [$];
  exp_t       e;
  int         wr_t [$];

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, n_wr = 0, n_rdy = 0, n_done = 0, n_abort = 0;
  int last_wr = 0, last_rdy = 0, abort_cyc = 0;
  bit have_wr = 0;
  logic prev_wr_n = 1'b1;
  logic [3:0] rdy_s = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic beat(input int r, input logic [7:0] d, input bit l);
    rq[r].push_back({l, d});
  endtask

  task automatic expect_wr(input int r, input logic [7:0] d);
    exp_t x;
    x.own = r;
    x.d   = d;
    sb.push_back(x);
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((sb.size() != 0 || busy === 1'b1) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, sb.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_wr(input string tag, input int n0);
    int n = 0;
    while (n_wr == n0 && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk(tag, 32'(n_wr > n0), 1);
  endtask

  // Requesters: present queue heads, pop on a sampled READY.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 4; i++) begin
      if (rdy_s[i] && rq[i].size() != 0) void'(rq[i].pop_front());
      req_valid[i] = (rq[i].size() != 0);
      req_data[8*i +: 8] = req_valid[i] ? rq[i][0][7:0] : 8'h00;
      req_last[i] = req_valid[i] ? rq[i][0][8] : 1'b0;
    end
    rdy_s = '0;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      rdy_s     = '0;
      prev_wr_n = 1'b1;
      have_wr   = 0;
    end else begin
      cyc++;
      rdy_s = req_ready;
      if (req_ready != 0) begin
        n_rdy++;
        last_rdy = cyc;
      end
      if (!csn || !wen) begin
        chk("csn_eq_wen", csn, wen);
        chk("wr_b2b", prev_wr_n, 1);
        if (have_wr) chk("wr_gap_min", 32'(cyc - last_wr >= 5), 1);
        if (sb.size() == 0) chk("wr_unexp", sb.size(), 1);
        else begin
          e = sb.pop_front();
          chk("wr_data", data_in, e.d);
          chk("wr_own", grant, 32'(1) << e.own);
        end
        wr_t.push_back(cyc);
        last_wr = cyc;
        have_wr = 1;
        n_wr++;
      end
      prev_wr_n = csn & wen;
      if (pkt_done) n_done++;
      if (abort) begin
        n_abort++;
        abort_cyc = cyc;
      end
      if (!busy) chk("grant_idle", grant, 0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, w0, r0, a0, t_on;

    repeat (3) @(negedge clk);
    chk("rst_csn", csn, 1);
    chk("rst_wen", wen, 1);
    chk("rst_data", data_in, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", pkt_done, 0);
    chk("rst_abort", abort, 0);
    chk("rst_ready", req_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single three-byte packet from requester 0.
    wr_t.delete();
    d0 = n_done;
    beat(0, 8'h41, 0); beat(0, 8'h42, 0); beat(0, 8'h43, 1);
    expect_wr(0, 8'h41); expect_wr(0, 8'h42); expect_wr(0, 8'h43);
    drain("single_drain", 200);
    chk("single_nwr", wr_t.size(), 3);
    if (wr_t.size() >= 3) begin
      chk("single_gap1", wr_t[1] - wr_t[0], 5);
      chk("single_gap2", wr_t[2] - wr_t[1], 5);
    end
    chk("single_done", n_done - d0, 1);
    chk("single_grant", grant, 0);

    // Timeout: requester 1 stalls mid-packet, requester 2 waits.
    wr_t.delete();
    d0 = n_done;
    a0 = n_abort;
    beat(1, 8'h51, 0);
    beat(2, 8'h61, 1);
    expect_wr(1, 8'h51); expect_wr(2, 8'h61);
    drain("tmo_drain", 300);
    chk("tmo_abort", n_abort - a0, 1);
    if (wr_t.size() >= 1) chk("tmo_lat", abort_cyc - wr_t[0], 14);
    chk("tmo_done", n_done - d0, 1);

    // One-byte packet from requester 3; pointer wraps to 0.
    w0 = n_wr;
    d0 = n_done;
    beat(3, 8'h3c, 1);
    expect_wr(3, 8'h3c);
    drain("one_drain", 100);
    chk("one_nwr", n_wr - w0, 1);
    chk("one_done", n_done - d0, 1);

    // Fairness: all requesters hold two 2-byte packets each.
    d0 = n_done;
    for (int rd = 0; rd < 2; rd++) begin
      for (int r = 0; r < 4; r++) begin
        beat(r, 8'(8'h80 + r * 16 + rd * 4), 0);
        beat(r, 8'(8'h81 + r * 16 + rd * 4), 1);
        expect_wr(r, 8'(8'h80 + r * 16 + rd * 4));
        expect_wr(r, 8'(8'h81 + r * 16 + rd * 4));
      end
    end
    drain("fair_drain", 600);
    chk("fair_done", n_done - d0, 8);

    // Backpressure: TXRDY low for 20 cycles after the first write.
    w0 = n_wr;
    beat(0, 8'h71, 0); beat(0, 8'h72, 0); beat(0, 8'h73, 1);
    expect_wr(0, 8'h71); expect_wr(0, 8'h72); expect_wr(0, 8'h73);
    wait_wr("bp_first", w0);
    txrdy = 1'b0;
    w0 = n_wr;
    r0 = n_rdy;
    repeat (20) @(negedge clk);
    chk("bp_no_wr", n_wr - w0, 0);
    chk("bp_no_rdy", n_rdy - r0, 0);
    @(posedge clk);
    #1 txrdy = 1'b1;
    t_on = cyc + 1;
    for (int n = 0; n < 20 && n_rdy == r0; n++) @(negedge clk);
    chk("bp_lat", last_rdy - t_on, 1);
    drain("bp_drain", 200);

    // Reset in the WRITE cycle of a packet from requester 1.
    w0 = n_wr;
    beat(1, 8'h91, 0); beat(1, 8'h92, 0); beat(1, 8'h93, 1);
    expect_wr(1, 8'h91);
    wait_wr("rst_first", w0);
    rst_n = 1'b0;
    #1;
    chk("mid_csn", csn, 1);
    chk("mid_wen", wen, 1);
    chk("mid_grant", grant, 0);
    chk("mid_busy", busy, 0);
    for (int i = 0; i < 4; i++) rq[i].delete();
    sb.delete();
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    beat(0, 8'ha1, 1);
    beat(1, 8'hb1, 1);
    expect_wr(0, 8'ha1); expect_wr(1, 8'hb1);
    drain("post_rst_drain", 200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
